// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Turns an asynchronous active-low reset plus a synchronous software reset
//   request into a set of staggered, synchronously released active-low resets.
//   Bit 0 releases first; each following bit releases RELEASE_GAP cycles later.
//
// Ports
//   clk          : single rising-edge clock
//   rstN         : asynchronous active-low reset (async assert, synchronised release)
//   soft_rst_req : synchronous active-high software reset request
//   sync_rstN    : sequenced active-low resets, thermometer-coded from bit 0
//   rst_done     : high once every sync_rstN bit is released
//   rst_cause    : cause of the last reset, 2'b01 hard, 2'b10 soft
module reset_sequencer #(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_OUTPUTS = 4,
  parameter int MIN_ASSERT  = 8,
  parameter int RELEASE_GAP = 4
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   soft_rst_req,
  output logic [NUM_OUTPUTS-1:0] sync_rstN,
  output logic                   rst_done,
  output logic [1:0]             rst_cause
);

  localparam int CNT_MAX = (MIN_ASSERT > RELEASE_GAP) ? MIN_ASSERT : RELEASE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]       ASSERT_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0]       GAP_LAST    = CNT_W'(RELEASE_GAP - 1);
  localparam logic [NUM_OUTPUTS-1:0] LSB_ONE     = NUM_OUTPUTS'(1);
  localparam logic [1:0]             CAUSE_HARD  = 2'b01;
  localparam logic [1:0]             CAUSE_SOFT  = 2'b10;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_DONE
  } state_t;

  logic [NUM_STAGES-1:0]  syncChain;
  logic                   srstN;
  state_t                 state, stateNext;
  logic [CNT_W-1:0]       cnt, cntNext;
  logic [NUM_OUTPUTS-1:0] rstVecNext;
  logic                   doneNext;
  logic [1:0]             causeNext;

  // Release synchroniser: a constant 1 walks through the chain after rstN rises.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      syncChain <= '0;
    end else begin
      syncChain <= {syncChain[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign srstN = syncChain[NUM_STAGES-1];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= ST_ASSERT;
      cnt       <= '0;
      sync_rstN <= '0;
      rst_done  <= 1'b0;
      rst_cause <= CAUSE_HARD;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      sync_rstN <= rstVecNext;
      rst_done  <= doneNext;
      rst_cause <= causeNext;
    end
  end

  // The counter counts elapsed cycles minus one, so the release happens on the
  // edge where it already holds the last value of the interval.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    rstVecNext = sync_rstN;
    doneNext   = rst_done;
    causeNext  = rst_cause;

    if (srstN) begin
      if (soft_rst_req) begin
        stateNext  = ST_ASSERT;
        cntNext    = '0;
        rstVecNext = '0;
        doneNext   = 1'b0;
        causeNext  = CAUSE_SOFT;
      end else begin
        case (state)
          ST_ASSERT: begin
            if (cnt == ASSERT_LAST) begin
              cntNext    = '0;
              rstVecNext = LSB_ONE;
              if (NUM_OUTPUTS == 1) begin
                stateNext = ST_DONE;
                doneNext  = 1'b1;
              end else begin
                stateNext = ST_RELEASE;
              end
            end else begin
              cntNext = cnt + 1'b1;
            end
          end
          ST_RELEASE: begin
            if (cnt == GAP_LAST) begin
              cntNext    = '0;
              rstVecNext = (sync_rstN << 1) | LSB_ONE;
              if (&rstVecNext) begin
                stateNext = ST_DONE;
                doneNext  = 1'b1;
              end
            end else begin
              cntNext = cnt + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Scoreboard bench for reset_sequencer. Two instances share clk, rstN and
//   soft_rst_req: dut0 uses the default parameters, dut1 uses NUM_STAGES=3,
//   NUM_OUTPUTS=1, MIN_ASSERT=1. Stimulus pushes expected output changes
//   (edge number, vector, done, cause) into per-instance queues; a monitor
//   pops one entry whenever an instance's outputs change.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       softReq = 1'b0;
  logic [3:0] rv0;
  logic       done0;
  logic [1:0] cause0;
  logic [0:0] rv1;
  logic       done1;
  logic [1:0] cause1;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_STAGES(2), .NUM_OUTPUTS(4), .MIN_ASSERT(8), .RELEASE_GAP(4)) u0 (
    .clk(clk), .rstN(rstN), .soft_rst_req(softReq),
    .sync_rstN(rv0), .rst_done(done0), .rst_cause(cause0)
  );

  reset_sequencer #(.NUM_STAGES(3), .NUM_OUTPUTS(1), .MIN_ASSERT(1), .RELEASE_GAP(4)) u1 (
    .clk(clk), .rstN(rstN), .soft_rst_req(softReq),
    .sync_rstN(rv1), .rst_done(done1), .rst_cause(cause1)
  );

  typedef struct {
    int         edgeNo;   // -1: asynchronous event, edge not checked
    logic [3:0] vec;
    logic       done;
    logic [1:0] cause;
    string      tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   edgeCnt = 0;
  int   checks = 0;
  int   errors = 0;
  bit   stress = 1'b0;
  bit   first = 1'b1;
  logic [6:0] prev0, prev1;

  always @(posedge clk) edgeCnt = edgeCnt + 1;

  function automatic void push(input int which, input int e, input logic [3:0] v,
                               input logic d, input logic [1:0] c, input string tag);
    exp_t x;
    x.edgeNo = e; x.vec = v; x.done = d; x.cause = c; x.tag = tag;
    if (which == 0) q0.push_back(x);
    else q1.push_back(x);
  endfunction

  function automatic void scoreEvent(input int which, input logic [3:0] v,
                                     input logic d, input logic [1:0] c);
    exp_t x;
    int   sz;
    checks++;
    sz = (which == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      errors++;
      $display("FAIL dut%0d unexpected_change: got vec=%b done=%b cause=%b at edge %0d, required no change",
               which, v, d, c, edgeCnt);
      return;
    end
    if (which == 0) x = q0.pop_front();
    else x = q1.pop_front();
    if ((x.edgeNo >= 0 && x.edgeNo != edgeCnt) || v !== x.vec || d !== x.done || c !== x.cause) begin
      errors++;
      $display("FAIL dut%0d %s: got edge=%0d vec=%b done=%b cause=%b, required edge=%0d vec=%b done=%b cause=%b",
               which, x.tag, edgeCnt, v, d, c, x.edgeNo, x.vec, x.done, x.cause);
    end
  endfunction

  // Monitor: scoreboard on output changes, plus continuous invariants.
  always @(negedge clk) begin
    logic [6:0] cur0, cur1;
    cur0 = {rv0, done0, cause0};
    cur1 = {3'b000, rv1, done1, cause1};
    if (!stress) begin
      if (first || cur0 != prev0) scoreEvent(0, rv0, done0, cause0);
      if (first || cur1 != prev1) scoreEvent(1, {3'b000, rv1}, done1, cause1);
    end
    prev0 = cur0;
    prev1 = cur1;
    first = 1'b0;

    checks += 3;
    if ((rv0 & (rv0 + 4'd1)) != 4'd0) begin
      errors++;
      $display("FAIL dut0 thermometer: got vec=%b at edge %0d, required thermometer code", rv0, edgeCnt);
    end
    if (done0 != &rv0) begin
      errors++;
      $display("FAIL dut0 done_vs_vec: got done=%b vec=%b, required done=%b", done0, rv0, &rv0);
    end
    if (done1 != rv1[0]) begin
      errors++;
      $display("FAIL dut1 done_vs_vec: got done=%b vec=%b, required done=%b", done1, rv1, rv1[0]);
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic waitUntil(input int e);
    while (edgeCnt < e) cyc(1);
  endtask

  initial begin
    int base, n, r;

    // Power-on hard reset
    push(0, -1, 4'b0000, 1'b0, 2'b01, "hard_reset");
    push(1, -1, 4'b0000, 1'b0, 2'b01, "hard_reset");
    #1 rstN = 1'b0;
    cyc(3);

    // Release: edge base+1 is edge 1
    base = edgeCnt;
    push(0, base + 10, 4'b0001, 1'b0, 2'b01, "hard_bit0");
    push(0, base + 14, 4'b0011, 1'b0, 2'b01, "hard_bit1");
    push(0, base + 18, 4'b0111, 1'b0, 2'b01, "hard_bit2");
    push(0, base + 22, 4'b1111, 1'b1, 2'b01, "hard_done");
    push(1, base + 4,  4'b0001, 1'b1, 2'b01, "hard_done_n1");
    rstN = 1'b1;
    waitUntil(base + 30);

    // Single soft request sampled at edge n from DONE
    n = edgeCnt + 1;
    push(0, n,      4'b0000, 1'b0, 2'b10, "soft_assert");
    push(0, n + 8,  4'b0001, 1'b0, 2'b10, "soft_bit0");
    push(0, n + 12, 4'b0011, 1'b0, 2'b10, "soft_bit1");
    push(0, n + 16, 4'b0111, 1'b0, 2'b10, "soft_bit2");
    push(0, n + 20, 4'b1111, 1'b1, 2'b10, "soft_done");
    push(1, n,      4'b0000, 1'b0, 2'b10, "soft_assert_n1");
    push(1, n + 1,  4'b0001, 1'b1, 2'b10, "soft_done_n1");
    softReq = 1'b1;
    cyc(1);
    softReq = 1'b0;
    waitUntil(n + 30);

    // Soft request held for edges n..n+4: timing counts from edge n+4
    n = edgeCnt + 1;
    push(0, n,      4'b0000, 1'b0, 2'b10, "held_assert");
    push(0, n + 12, 4'b0001, 1'b0, 2'b10, "held_bit0");
    push(0, n + 16, 4'b0011, 1'b0, 2'b10, "held_bit1");
    push(0, n + 20, 4'b0111, 1'b0, 2'b10, "held_bit2");
    push(0, n + 24, 4'b1111, 1'b1, 2'b10, "held_done");
    push(1, n,      4'b0000, 1'b0, 2'b10, "held_assert_n1");
    push(1, n + 5,  4'b0001, 1'b1, 2'b10, "held_done_n1");
    softReq = 1'b1;
    cyc(5);
    softReq = 1'b0;
    waitUntil(n + 35);

    // Hard reset, then a sub-cycle rstN glitch between edges 15 and 16
    push(0, -1, 4'b0000, 1'b0, 2'b01, "hard2_assert");
    push(1, -1, 4'b0000, 1'b0, 2'b01, "hard2_assert_n1");
    rstN = 1'b0;
    cyc(2);
    base = edgeCnt;
    push(0, base + 10, 4'b0001, 1'b0, 2'b01, "hard2_bit0");
    push(0, base + 14, 4'b0011, 1'b0, 2'b01, "hard2_bit1");
    push(1, base + 4,  4'b0001, 1'b1, 2'b01, "hard2_done_n1");
    rstN = 1'b1;
    waitUntil(base + 15);
    push(0, -1,        4'b0000, 1'b0, 2'b01, "glitch_abort");
    push(0, base + 25, 4'b0001, 1'b0, 2'b01, "glitch_bit0");
    push(0, base + 29, 4'b0011, 1'b0, 2'b01, "glitch_bit1");
    push(0, base + 33, 4'b0111, 1'b0, 2'b01, "glitch_bit2");
    push(0, base + 37, 4'b1111, 1'b1, 2'b01, "glitch_done");
    push(1, -1,        4'b0000, 1'b0, 2'b01, "glitch_abort_n1");
    push(1, base + 19, 4'b0001, 1'b1, 2'b01, "glitch_done_n1");
    rstN = 1'b0;
    #2 rstN = 1'b1;
    waitUntil(base + 45);

    checks += 2;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL dut0 pending_events: got %0d unconsumed, required 0", q0.size());
    end
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL dut1 pending_events: got %0d unconsumed, required 0", q1.size());
    end

    // Random soft/hard stress: only the invariants are checked here
    stress = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      softReq = (r < 6);
      if (r >= 97) begin
        rstN = 1'b0;
        #2 rstN = 1'b1;
      end
      cyc(1);
    end
    softReq = 1'b0;
    cyc(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 2, synchronizer depth; legal range 2-10.
REQ-002 Parameter NUM_OUTPUTS, default 4, number of sequenced reset outputs; legal range 1-16.
REQ-003 Parameter MIN_ASSERT, default 8, minimum cycles all outputs stay asserted after the reset source is released; legal range >=1.
REQ-004 Parameter RELEASE_GAP, default 4, cycles between successive output releases; legal range >=1.
REQ-005 Port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 Port rstN, input, 1, asynchronous active-low reset; asserts asynchronously, deasserts synchronously through the NUM_STAGES chain.
REQ-007 Port soft_rst_req, input, 1, synchronous active-high software reset request in the clk domain.
REQ-008 Port sync_rstN, output, NUM_OUTPUTS, active-low sequenced resets; bit 0 releases first.
REQ-009 Port rst_done, output, 1, high when every sync_rstN bit is released.
REQ-010 Port rst_cause, output, 2, cause of the last reset: 2'b01 = hard (rstN), 2'b10 = soft.

Function
REQ-011 The synchronizer shall be NUM_STAGES flops, each async-cleared by rstN, with D of stage 0 tied to 1; its last stage is srst_n.
REQ-012 The FSM shall have states ASSERT, RELEASE and DONE, with a counter sized for max(MIN_ASSERT, RELEASE_GAP).
REQ-013 ASSERT: all sync_rstN = 0 and rst_done = 0; the counter runs only while srst_n = 1; when MIN_ASSERT cycles have elapsed, release sync_rstN[0] and go to RELEASE.
REQ-014 RELEASE: every RELEASE_GAP cycles, release the next bit in ascending index; when bit NUM_OUTPUTS-1 releases, set rst_done = 1 on the same edge and go to DONE.
REQ-015 With NUM_OUTPUTS = 1, the FSM shall go from ASSERT directly to DONE; sync_rstN[0] and rst_done rise on the same edge.
REQ-016 Timing after rstN deasserts (setup met before edge 1):
  - srst_n is high after edge NUM_STAGES.
  - sync_rstN[0] rises at edge NUM_STAGES+MIN_ASSERT.
  - sync_rstN[k] rises RELEASE_GAP edges after sync_rstN[k-1].
REQ-017 Released bits shall stay released until the next reset; the outputs shall be thermometer-coded at all times (bit k released implies bit k-1 released).
REQ-018 soft_rst_req sampled high at edge n, in any state with srst_n = 1:
  - all sync_rstN = 0, rst_done = 0 and rst_cause = 2'b10 after edge n.
  - The FSM enters ASSERT with the counter cleared.
  - sync_rstN[0] rises at edge n+MIN_ASSERT.
REQ-019 soft_rst_req held high shall retrigger every cycle; release timing counts from the last edge at which it was sampled high.
REQ-020 soft_rst_req during ASSERT or RELEASE shall restart the sequence from ASSERT per REQ-018.
REQ-021 soft_rst_req shall be ignored while srst_n = 0.
REQ-022 All outputs shall be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-023 rstN low shall asynchronously, with no clock edge:
  - set all sync_rstN = 0 and rst_done = 0;
  - set rst_cause = 2'b01;
  - clear the synchronizer, FSM (ASSERT) and counter.
REQ-024 rstN assertion in any state, including mid-RELEASE, shall abort the sequence; the full sequence reruns after release.
REQ-025 An rstN glitch shorter than one clock shall still fully reset the block and restart the sequence per REQ-016.

Verification
REQ-026 Defaults, rstN released before edge 1 -> sync_rstN[0..3] rise at edges 10, 14, 18, 22; rst_done at edge 22; rst_cause = 01.
REQ-027 Defaults, DONE, soft_rst_req high at edge 100 -> sync_rstN = 0000 after edge 100; bit 0 rises at edge 108, bit 3 and rst_done at edge 120; rst_cause = 10.
REQ-028 Defaults, soft_rst_req high at edges 100-104 -> outputs low throughout; bit 0 rises at edge 112.
REQ-029 Defaults, rstN pulsed low between edges 15 and 16 (bits 0-1 released) -> all outputs 0 immediately; bit 0 rises at edge 25, rst_done at edge 37; rst_cause = 01.
REQ-030 NUM_STAGES=3, NUM_OUTPUTS=1, MIN_ASSERT=1 -> sync_rstN[0] and rst_done rise together at edge 4.
REQ-031 Random soft/hard reset stress, run with all parameter sets above -> check continuously that sync_rstN is thermometer-coded and that rst_done = &sync_rstN.
